// File: rtl/ram8x8_block_reader_if.sv
// Purpose: groups the control, RAM read-port and sample-stream signals of the 8x8 block reader.
// Latency: none, this is wiring only.
// Backpressure: m_ready (master to slave) stalls the stream; the reader holds m_data while stalled.
interface ram8x8_block_reader_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [5:0]       rd_addr;
  logic             rd_en;
  logic [WIDTH-1:0] ram_dout;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  // Reader's view of the bus.
  modport slave (
    input  start, mode, ram_dout, m_ready,
    output busy, done, rd_addr, rd_en, m_data, m_valid, m_last
  );

  // Surrounding system's view: control source, RAM and sample sink.
  modport master (
    output start, mode, ram_dout, m_ready,
    input  busy, done, rd_addr, rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ram8x8_block_reader.sv
// Purpose: reads one 8x8 block from the block RAM in raster, transposed or zigzag order and streams it.
// Latency: start at edge 0 -> first rd_en in cycle 1 -> first m_valid in cycle 3; done one cycle after the 64th beat.
// Backpressure: at most two samples are held (FIFO plus in-flight read); reads pause while m_ready is low.
module ram8x8_block_reader #(
  parameter int WIDTH = 8,
  parameter int BLK_N = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ram8x8_block_reader_if.slave  bus
);

  localparam logic [5:0] LAST_IDX = 6'(BLK_N * BLK_N - 1);

  // Zigzag scan position -> raster address.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [6:0]       r_k;         // issue index, bit 6 set once all 64 reads are issued
  logic [5:0]       r_o;         // output beat index
  logic             r_inflight;  // a read was issued last cycle; ram_dout is valid now
  logic             r_done;
  logic [WIDTH-1:0] r_fifo [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic             w_start_acc;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_last_hs;
  logic [1:0]       w_pending;
  logic [5:0]       w_addr;

  assign w_push    = r_inflight;
  assign w_pop     = (r_count != 2'd0) & bus.m_ready;
  assign w_last_hs = w_pop & (r_o == LAST_IDX);
  // Samples already committed to the output side: stored plus the one arriving from the RAM.
  assign w_pending = r_count + {1'b0, r_inflight};

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, start acceptance and read issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_start_acc = 1'b1;
        end
      end
      S_RUN: begin
        // Issue only if the sample can be stored, counting a pop in this same cycle as freeing a slot.
        if (!r_k[6] && ((w_pending < 2'd2) || ((w_pending == 2'd2) && w_pop))) begin
          w_issue = 1'b1;
        end
        if (w_last_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Map the issue index to a RAM address for the latched read order.
  always_comb begin
    w_addr = r_k[5:0];
    case (r_mode)
      2'd1:    w_addr = {r_k[2:0], r_k[5:3]};
      2'd2:    w_addr = ZZ[r_k[5:0]];
      default: w_addr = r_k[5:0];
    endcase
  end

  // Block counters, mode latch, in-flight flag and done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode     <= 2'd0;
      r_k        <= 7'd0;
      r_o        <= 6'd0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_last_hs;
      if (w_start_acc) begin
        r_mode <= bus.mode;
        r_k    <= 7'd0;
        r_o    <= 6'd0;
      end else begin
        if (w_issue) begin
          r_k <= r_k + 7'd1;
        end
        if (w_pop) begin
          r_o <= r_o + 6'd1;
        end
      end
    end
  end

  // Two-entry output FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: capture the RAM word in the cycle after its read was issued.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.ram_dout;
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = r_done;
  assign bus.rd_en   = w_issue;
  assign bus.rd_addr = w_addr;
  assign bus.m_valid = (r_count != 2'd0);
  assign bus.m_data  = r_fifo[r_rd_ptr];
  assign bus.m_last  = (r_count != 2'd0) & (r_o == LAST_IDX);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
